shift_ex_stage: RTL and testbench
=================================

Name: shift_ex_stage

Overview:
- Execute-stage wrapper for the 16-bit SLL/SRA/ROR shifter in the pipelined CPU.
- Captures decoded shift instructions from decode into an operand register.
- Applies EX/MEM and MEM/WB operand forwarding, then drives the shifter's Shift_In, Shift_Val and Mode.
- Registers the shifter output into a result register with a valid/ready handshake toward the memory stage.

Parameters:
- DW, 16, datapath width (fixed at 16; the shifter is 16-bit only)
- RW, 4, register index width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents a shift instruction
- in_ready  out  1  stage can accept
- in_op  in  2  shift mode: 00 SLL, 01 SRA, 10 ROR, 11 reserved
- in_rs_idx  in  RW  source register index
- in_rs_data  in  DW  register-file value of rs
- in_imm  in  4  shift amount
- in_rd_idx  in  RW  destination register index
- flush  in  1  squash all in-flight instructions (branch mispredict)
- exm_wr, exm_idx, exm_data  in  1/RW/DW  EX/MEM forwarding source
- mwb_wr, mwb_idx, mwb_data  in  1/RW/DW  MEM/WB forwarding source
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  memory stage accepts the result
- out_data  out  DW  shifted result
- out_rd_idx  out  RW  destination index of the result

Behaviour:
- Two registered stages:
  - S1: operand register holding s1_valid, op, rs_idx, rs_data, imm, rd_idx.
  - S2: result register holding out_valid, out_data, out_rd_idx.
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_data=0x0000, out_rd_idx=0, all S1 fields=0. in_ready reads 1 once rst_n=1.
- s2_free = !out_valid || out_ready.
- s1_adv = s1_valid && s2_free.
- in_ready = !s1_valid || s2_free. This is combinational, has no dependence on in_valid, and gives full throughput of 1 instruction/cycle.
- S1 load:
  - When in_valid && in_ready, capture all in_* fields and set s1_valid=1.
  - Otherwise, if s1_adv, clear s1_valid.
  - Otherwise hold all fields.
- Forwarding (combinational from S1), computing the effective operand opnd:
  - If exm_wr && exm_idx==s1 rs_idx && exm_idx!=0, use exm_data.
  - Else if mwb_wr && mwb_idx==s1 rs_idx && mwb_idx!=0, use mwb_data.
  - Else use the captured rs_data.
  - EX/MEM has priority. Register 0 is never forwarded.
  - Forwarding is re-evaluated every cycle while S1 is stalled, so a producer that arrives during the stall is picked up.
- Shifter drive: Shift_In=opnd, Shift_Val=imm, Mode=op.
  - op 11 yields SLL, per the shifter's definition.
  - Shift amount 0 passes the operand through unchanged in all modes.
- S2 load:
  - On s1_adv, out_data and out_rd_idx take the shifter output and out_valid=1.
  - Otherwise, if out_valid && out_ready, out_valid=0.
  - Otherwise hold. out_data is stable while out_valid && !out_ready.
- Latency: instruction accepted at edge N gives out_valid at edge N+2 when out_ready stays high.
- Flush:
  - Synchronous. At the next edge, s1_valid=0 and out_valid=0.
  - A simultaneous in_valid is dropped: no capture, in_ready is ignored for that edge.
  - Data fields may keep stale values.
- Simultaneous S1 load and S1 advance in one edge: S1 takes the new instruction and S2 takes the old one. No bubble.
- Reset mid-operation: in-flight instructions are discarded immediately. There is no output glitch beyond out_valid dropping asynchronously.

Optional Feature:
- Macro SHIFT_EX_ZFLAG_EN.
- When defined, two extra ports are added:
  - out_zf  out  1: registered with out_data, set to (shifter output == 0) on s1_adv, held otherwise. Reset value 0.
  - out_zf_wr  out  1: equals out_valid.
- When undefined, neither port exists and no flag logic is generated.

Test Plan:
- Reset, then single-issue SLL rs=0x0001 imm=4 rd=3, out_ready=1 -> out_valid high 2 cycles after accept, out_data=0x0010, out_rd_idx=3.
- Back-to-back issue over 3 cycles:
  - SRA 0x8000 imm=3 -> 0xF000
  - ROR 0x1234 imm=4 -> 0x4123
  - ROR 0x1234 imm=8 -> 0x3412
  - Results appear on 3 consecutive cycles with in_ready constant 1.
- Backpressure with out_ready=0 for 4 cycles while issuing 3 instructions:
  - in_ready drops after the second accept.
  - out_data is held at the first result.
  - On release, all results drain in order with none lost or duplicated.
- Forwarding with S1 holding rs_idx=5, rs_data=0x0000, SLL imm=1:
  - exm_wr=1, exm_idx=5, exm_data=0x00F0 together with mwb_wr=1, mwb_idx=5, mwb_data=0x000F -> out_data=0x01E0.
  - Same case with rs_idx=0 -> out_data=0x0000.
- Flush asserted with both stages valid and in_valid=1 -> next cycle out_valid=0, s1 empty, no output appears for any of the 3 instructions.
- Reset asserted while out_valid=1 with out_ready=0 -> out_valid=0 and out_data=0x0000 immediately. After release, a new SLL 0x0003 imm=15 -> 0x8000; with SHIFT_EX_ZFLAG_EN, SLL 0x8000 imm=1 -> out_data=0x0000, out_zf=1.

Source files
------------

// File: rtl/shift_ex_stage_if.sv
// Execute-stage shifter bus: decode-side issue handshake and memory-side result handshake.
// The zero-flag pair (out_zf, out_zf_wr) exists only when SHIFT_EX_ZFLAG_EN is defined.
interface shift_ex_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [RW-1:0] in_rs_idx;
  logic [DW-1:0] in_rs_data;
  logic [3:0]    in_imm;
  logic [RW-1:0] in_rd_idx;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd_idx;

`ifdef SHIFT_EX_ZFLAG_EN
  logic          out_zf;
  logic          out_zf_wr;

  modport master (
    output in_valid, in_op, in_rs_idx, in_rs_data, in_imm, in_rd_idx, out_ready,
    input  in_ready, out_valid, out_data, out_rd_idx, out_zf, out_zf_wr
  );

  modport slave (
    input  in_valid, in_op, in_rs_idx, in_rs_data, in_imm, in_rd_idx, out_ready,
    output in_ready, out_valid, out_data, out_rd_idx, out_zf, out_zf_wr
  );
`else
  modport master (
    output in_valid, in_op, in_rs_idx, in_rs_data, in_imm, in_rd_idx, out_ready,
    input  in_ready, out_valid, out_data, out_rd_idx
  );

  modport slave (
    input  in_valid, in_op, in_rs_idx, in_rs_data, in_imm, in_rd_idx, out_ready,
    output in_ready, out_valid, out_data, out_rd_idx
  );
`endif
endinterface

// File: rtl/shift_ex_stage.sv
// Execute stage for the 16-bit SLL/SRA/ROR shifter: operand register, EX/MEM + MEM/WB forwarding,
// result register with valid/ready toward memory. Define SHIFT_EX_ZFLAG_EN to add the zero flag.
module shift_ex_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            exm_wr,
  input  logic [RW-1:0]   exm_idx,
  input  logic [DW-1:0]   exm_data,
  input  logic            mwb_wr,
  input  logic [RW-1:0]   mwb_idx,
  input  logic [DW-1:0]   mwb_data,
  shift_ex_stage_if.slave bus
);
  localparam int unsigned OPW = 2;
  localparam int unsigned SHW = 4;
  localparam int unsigned RTW = 5;

  typedef enum logic [OPW-1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // S1 operand register
  logic          s1_valid;
  mode_e         s1_op;
  logic [RW-1:0] s1_rs_idx;
  logic [DW-1:0] s1_rs_data;
  logic [SHW-1:0] s1_imm;
  logic [RW-1:0] s1_rd_idx;

  // S2 result register
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [RW-1:0] out_rd_idx_q;

  logic          s2_free;
  logic          s1_adv;
  logic          in_ready_c;
  logic          s1_load;
  logic [DW-1:0] opnd;
  logic [DW-1:0] shift_res;

  assign s2_free    = !out_valid_q || bus.out_ready;
  assign s1_adv     = s1_valid && s2_free;
  assign in_ready_c = !s1_valid || s2_free;
  assign s1_load    = bus.in_valid && in_ready_c && !flush;

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_rd_idx = out_rd_idx_q;

  // Operand forwarding, re-evaluated every cycle so a stalled S1 sees late producers
  always_comb begin
    opnd = s1_rs_data;
    if (exm_wr && (exm_idx == s1_rs_idx) && (exm_idx != '0)) begin
      opnd = exm_data;
    end else if (mwb_wr && (mwb_idx == s1_rs_idx) && (mwb_idx != '0)) begin
      opnd = mwb_data;
    end
  end

  // Shifter; the reserved mode and any zero amount fall through as SLL / pass-through
  always_comb begin
    shift_res = opnd << s1_imm;
    case (s1_op)
      MODE_SRA: shift_res = DW'($signed(opnd) >>> s1_imm);
      MODE_ROR: shift_res = (opnd >> s1_imm) | (opnd << (RTW'(DW) - {1'b0, s1_imm}));
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= MODE_SLL;
      s1_rs_idx  <= '0;
      s1_rs_data <= '0;
      s1_imm     <= '0;
      s1_rd_idx  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid   <= 1'b1;
      s1_op      <= mode_e'(bus.in_op);
      s1_rs_idx  <= bus.in_rs_idx;
      s1_rs_data <= bus.in_rs_data;
      s1_imm     <= bus.in_imm;
      s1_rd_idx  <= bus.in_rd_idx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rd_idx_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= shift_res;
      out_rd_idx_q <= s1_rd_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef SHIFT_EX_ZFLAG_EN
  logic out_zf_q;

  // Zero flag travels with out_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zf_q <= 1'b0;
    end else if (!flush && s1_adv) begin
      out_zf_q <= (shift_res == '0);
    end
  end

  assign bus.out_zf    = out_zf_q;
  assign bus.out_zf_wr = out_valid_q;
`endif

endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage: directed vector table, multi-cycle corner sequences,
// and a randomized run compared against an arithmetic transaction model.
`timescale 1ns/1ps
module tb_shift_ex_stage;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int NVEC = 14;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          exm_wr;
  logic [RW-1:0] exm_idx;
  logic [DW-1:0] exm_data;
  logic          mwb_wr;
  logic [RW-1:0] mwb_idx;
  logic [DW-1:0] mwb_data;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] v;
    logic [3:0]    amt;
    logic [RW-1:0] rd;
    logic [DW-1:0] want;
  } vec_t;

  vec_t vecs [NVEC];

  // transaction model state (contents of each stage after the next edge)
  logic          m_s1_v;
  logic [1:0]    m_s1_op;
  logic [RW-1:0] m_s1_idx;
  logic [DW-1:0] m_s1_data;
  logic [3:0]    m_s1_imm;
  logic [RW-1:0] m_s1_rd;
  logic          m_s2_v;
  logic [DW-1:0] m_s2_data;
  logic [RW-1:0] m_s2_rd;
  logic          m_s2_zf;

  shift_ex_stage_if #(.DW(DW), .RW(RW)) bus ();

  shift_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .exm_wr   (exm_wr),
    .exm_idx  (exm_idx),
    .exm_data (exm_data),
    .mwb_wr   (mwb_wr),
    .mwb_idx  (mwb_idx),
    .mwb_data (mwb_data),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Shift result from plain arithmetic: multiply/divide by 2**amt
  function automatic logic [DW-1:0] ref_shift(input logic [1:0] op, input logic [DW-1:0] v,
                                              input logic [3:0] amt);
    longint u, p, s, q;
    u = longint'(v);
    p = 1;
    for (int i = 0; i < int'(amt); i++) p = p * 2;
    case (op)
      2'b01: begin
        s = v[DW-1] ? u - 65536 : u;
        q = (s >= 0) ? s / p : -((-s + p - 1) / p);
      end
      2'b10:   q = (u * 65537) / p;
      default: q = u * p;
    endcase
    return DW'(q);
  endfunction

  task automatic drive_in(input logic v, input logic [1:0] op, input logic [RW-1:0] rs,
                          input logic [DW-1:0] d, input logic [3:0] imm, input logic [RW-1:0] rd);
    bus.in_valid   = v;
    bus.in_op      = op;
    bus.in_rs_idx  = rs;
    bus.in_rs_data = d;
    bus.in_imm     = imm;
    bus.in_rd_idx  = rd;
  endtask

  task automatic set_fwd(input logic ew, input logic [RW-1:0] ei, input logic [DW-1:0] ed,
                         input logic mw, input logic [RW-1:0] mi, input logic [DW-1:0] md);
    exm_wr = ew; exm_idx = ei; exm_data = ed;
    mwb_wr = mw; mwb_idx = mi; mwb_data = md;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 2'b00, '0, '0, 4'd0, '0);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_out(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one instruction into an idle stage and check the result it produces
  task automatic issue_chk(input string name, input logic [1:0] op, input logic [RW-1:0] rs,
                           input logic [DW-1:0] d, input logic [3:0] imm,
                           input logic [RW-1:0] rd, input logic [DW-1:0] want);
    bit ok;
    bus.out_ready = 1'b1;
    drive_in(1'b1, op, rs, d, imm, rd);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(name, ok);
    if (ok) begin
      chk({name, "_data"}, 32'(bus.out_data), 32'(want));
      chk({name, "_rd"}, 32'(bus.out_rd_idx), 32'(rd));
`ifdef SHIFT_EX_ZFLAG_EN
      chk({name, "_zf"}, 32'(bus.out_zf), 32'(want == '0));
      chk({name, "_zfwr"}, 32'(bus.out_zf_wr), 32'd1);
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] got_d [3];
    int            got_n;
    logic [DW-1:0] opnd;
    logic          rdy;
    logic          adv;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 2'b00, '0, '0, 4'd0, '0);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    vecs[0]  = '{2'b00, 16'h0001, 4'd4,  4'd3,  16'h0010};
    vecs[1]  = '{2'b01, 16'h8000, 4'd3,  4'd1,  16'hF000};
    vecs[2]  = '{2'b10, 16'h1234, 4'd4,  4'd2,  16'h4123};
    vecs[3]  = '{2'b10, 16'h1234, 4'd8,  4'd4,  16'h3412};
    vecs[4]  = '{2'b00, 16'h0003, 4'd15, 4'd5,  16'h8000};
    vecs[5]  = '{2'b11, 16'h0001, 4'd2,  4'd6,  16'h0004};
    vecs[6]  = '{2'b00, 16'hABCD, 4'd0,  4'd7,  16'hABCD};
    vecs[7]  = '{2'b01, 16'h8001, 4'd0,  4'd8,  16'h8001};
    vecs[8]  = '{2'b10, 16'h1234, 4'd0,  4'd9,  16'h1234};
    vecs[9]  = '{2'b01, 16'h7FFF, 4'd15, 4'd10, 16'h0000};
    vecs[10] = '{2'b01, 16'hFFFF, 4'd15, 4'd11, 16'hFFFF};
    vecs[11] = '{2'b10, 16'h0001, 4'd1,  4'd12, 16'h8000};
    vecs[12] = '{2'b01, 16'h8000, 4'd15, 4'd13, 16'hFFFF};
    vecs[13] = '{2'b10, 16'h8421, 4'd15, 4'd14, 16'h0843};

    // reset values while rst_n is low, then ready after release
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // back-to-back vector table: each result two edges after its accept
    bus.out_ready = 1'b1;
    for (int c = 0; c < NVEC + 2; c++) begin
      if (c == 1) chk("vec_latency_early", 32'(bus.out_valid), 32'd0);
      if (c >= 2) begin
        chk($sformatf("vec%0d_valid", c - 2), 32'(bus.out_valid), 32'd1);
        chk($sformatf("vec%0d_data", c - 2), 32'(bus.out_data), 32'(vecs[c-2].want));
        chk($sformatf("vec%0d_rd", c - 2), 32'(bus.out_rd_idx), 32'(vecs[c-2].rd));
      end
      if (c < NVEC) begin
        chk($sformatf("vec%0d_in_ready", c), 32'(bus.in_ready), 32'd1);
        drive_in(1'b1, vecs[c].op, 4'd1, vecs[c].v, vecs[c].amt, vecs[c].rd);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("vec_drained", 32'(bus.out_valid), 32'd0);

    // backpressure: three issues against a stalled memory stage
    bus.out_ready = 1'b0;
    drive_in(1'b1, 2'b00, 4'd1, 16'h0001, 4'd1, 4'd1);
    @(negedge clk);
    chk("bp_ready_1", 32'(bus.in_ready), 32'd1);
    drive_in(1'b1, 2'b10, 4'd2, 16'h00F0, 4'd4, 4'd2);
    @(negedge clk);
    chk("bp_ready_2", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_0", 32'(bus.out_data), 32'h0002);
    drive_in(1'b1, 2'b01, 4'd3, 16'hF00F, 4'd4, 4'd3);
    @(negedge clk);
    chk("bp_ready_3", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_1", 32'(bus.out_data), 32'h0002);
    @(negedge clk);
    chk("bp_hold_2", 32'(bus.out_data), 32'h0002);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    got_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (got_n < 3) got_d[got_n] = bus.out_data;
        got_n++;
      end
      @(negedge clk);
    end
    chk("bp_count", 32'(got_n), 32'd3);
    if (got_n >= 3) begin
      chk("bp_order_0", 32'(got_d[0]), 32'h0002);
      chk("bp_order_1", 32'(got_d[1]), 32'h000F);
      chk("bp_order_2", 32'(got_d[2]), 32'hFF00);
    end

    // forwarding priority and register-0 exclusion
    set_fwd(1'b1, 4'd5, 16'h00F0, 1'b1, 4'd5, 16'h000F);
    issue_chk("fwd_exm_pri", 2'b00, 4'd5, 16'h0000, 4'd1, 4'd3, 16'h01E0);
    set_fwd(1'b1, 4'd0, 16'h00F0, 1'b1, 4'd0, 16'h000F);
    issue_chk("fwd_r0", 2'b00, 4'd0, 16'h0000, 4'd1, 4'd3, 16'h0000);
    set_fwd(1'b0, 4'd5, 16'h00F0, 1'b1, 4'd5, 16'h000F);
    issue_chk("fwd_mwb_only", 2'b00, 4'd5, 16'h0000, 4'd1, 4'd4, 16'h001E);
    set_fwd(1'b1, 4'd6, 16'h00F0, 1'b1, 4'd5, 16'h000F);
    issue_chk("fwd_exm_miss", 2'b00, 4'd5, 16'h0000, 4'd1, 4'd4, 16'h001E);
    set_fwd(1'b1, 4'd6, 16'h00F0, 1'b1, 4'd7, 16'h000F);
    issue_chk("fwd_none", 2'b01, 4'd5, 16'h0101, 4'd1, 4'd4, 16'h0080);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // producer arriving while S1 is stalled is picked up
    bus.out_ready = 1'b0;
    drive_in(1'b1, 2'b00, 4'd1, 16'h0001, 4'd0, 4'd1);
    @(negedge clk);
    drive_in(1'b1, 2'b00, 4'd5, 16'h0000, 4'd1, 4'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    set_fwd(1'b1, 4'd5, 16'h0100, 1'b0, '0, '0);
    @(negedge clk);
    chk("stall_first", 32'(bus.out_data), 32'h0001);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_fwd_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_fwd_data", 32'(bus.out_data), 32'h0200);
    chk("stall_fwd_rd", 32'(bus.out_rd_idx), 32'd2);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);

    // flush with both stages full and a new instruction presented
    bus.out_ready = 1'b0;
    drive_in(1'b1, 2'b00, 4'd1, 16'h0001, 4'd1, 4'd1);
    @(negedge clk);
    drive_in(1'b1, 2'b00, 4'd1, 16'h0002, 4'd1, 4'd2);
    @(negedge clk);
    chk("flush_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    drive_in(1'b1, 2'b00, 4'd1, 16'h0003, 4'd1, 4'd3);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    got_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) got_n++;
    end
    chk("flush_no_output", 32'(got_n), 32'd0);

    // asynchronous reset with a stalled valid result
    bus.out_ready = 1'b0;
    drive_in(1'b1, 2'b00, 4'd1, 16'h00FF, 4'd4, 4'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data", 32'(bus.out_data), 32'd0);
    chk("mrst_out_rd", 32'(bus.out_rd_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    issue_chk("mrst_sll15", 2'b00, 4'd1, 16'h0003, 4'd15, 4'd5, 16'h8000);
`ifdef SHIFT_EX_ZFLAG_EN
    issue_chk("zf_sll_out", 2'b00, 4'd1, 16'h8000, 4'd1, 4'd6, 16'h0000);
`endif

    // randomized traffic against the transaction model
    do_reset();
    m_s1_v = 1'b0; m_s1_op = '0; m_s1_idx = '0; m_s1_data = '0; m_s1_imm = '0; m_s1_rd = '0;
    m_s2_v = 1'b0; m_s2_data = '0; m_s2_rd = '0; m_s2_zf = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk($sformatf("rnd%0d_valid", cyc), 32'(bus.out_valid), 32'(m_s2_v));
      if (m_s2_v) begin
        chk($sformatf("rnd%0d_data", cyc), 32'(bus.out_data), 32'(m_s2_data));
        chk($sformatf("rnd%0d_rd", cyc), 32'(bus.out_rd_idx), 32'(m_s2_rd));
`ifdef SHIFT_EX_ZFLAG_EN
        chk($sformatf("rnd%0d_zf", cyc), 32'(bus.out_zf), 32'(m_s2_zf));
`endif
      end
      chk($sformatf("rnd%0d_in_ready", cyc), 32'(bus.in_ready),
          32'(!m_s1_v || !m_s2_v || bus.out_ready));

      drive_in(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               RW'($urandom_range(0, 3)), DW'($urandom), 4'($urandom_range(0, 15)),
               RW'($urandom_range(0, 15)));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 19) == 0);
      set_fwd(1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)), DW'($urandom),
              1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)), DW'($urandom));

      opnd = m_s1_data;
      if (exm_wr && exm_idx == m_s1_idx && exm_idx != '0) opnd = exm_data;
      else if (mwb_wr && mwb_idx == m_s1_idx && mwb_idx != '0) opnd = mwb_data;
      rdy = !m_s1_v || !m_s2_v || bus.out_ready;
      adv = m_s1_v && (!m_s2_v || bus.out_ready);

      if (flush) begin
        m_s1_v = 1'b0;
        m_s2_v = 1'b0;
      end else begin
        if (adv) begin
          m_s2_v    = 1'b1;
          m_s2_data = ref_shift(m_s1_op, opnd, m_s1_imm);
          m_s2_rd   = m_s1_rd;
          m_s2_zf   = (m_s2_data == '0);
        end else if (bus.out_ready) begin
          m_s2_v = 1'b0;
        end
        if (bus.in_valid && rdy) begin
          m_s1_v    = 1'b1;
          m_s1_op   = bus.in_op;
          m_s1_idx  = bus.in_rs_idx;
          m_s1_data = bus.in_rs_data;
          m_s1_imm  = bus.in_imm;
          m_s1_rd   = bus.in_rd_idx;
        end else if (adv) begin
          m_s1_v = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
